icache_ctrl: RTL and testbench
==============================

Name: icache_ctrl

Overview:
- Direct-mapped, one-word-per-line instruction cache controller between the instruction fetch unit and the IF requester port of the shared byte-wide memory controller.
- Hits return in 1 cycle with no memory traffic.
- Misses issue a single word request to the memory controller, hold it until the 4-byte fetch completes, fill the line, then forward the word.
- A ROB flush aborts an outstanding miss; the memory controller resets its own sequencing on the same flush.

Parameters:
- INDEX_WIDTH, 8, number of index bits; line count = 2^INDEX_WIDTH, one 32-bit word per line.
- TAG_WIDTH, 32-2-INDEX_WIDTH, tag bits = pc[31:INDEX_WIDTH+2]; derived, not overridden.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  asynchronous active-high reset
- rdy_in  input  1  global ready; low = freeze
- ifetch_en_in  input  1  fetch request pulse, sampled in IDLE only
- ifetch_pc_in  input  32  fetch address, word aligned
- ifetch_en_out  output  1  1-cycle pulse: ifetch_inst_out valid
- ifetch_inst_out  output  32  fetched instruction
- mem_en_out  output  1  word request to memory controller, level, held until mem_en_in
- mem_pc_out  output  32  request address, stable while mem_en_out=1
- mem_en_in  input  1  1-cycle pulse: mem_inst_in valid
- mem_inst_in  input  32  word from memory controller
- flush_in  input  1  ROB flush

Behaviour:
- Reset (async, any state):
  - ifetch_en_out=0, ifetch_inst_out=0, mem_en_out=0, mem_pc_out=0.
  - All valid bits=0, state=IDLE.
  - Data/tag arrays are not cleared.
- Address split: index=pc[INDEX_WIDTH+1:2], tag=pc[31:INDEX_WIDTH+2]; pc[1:0] ignored.
- rdy_in=0: state, arrays and all outputs hold; ifetch_en_out forced 0 that cycle; no input sampled.
- ifetch_en_out defaults to 0 each active cycle (pulse).
- IDLE:
  - ifetch_en_in=1 and valid[index] and tag match: next edge ifetch_inst_out<=data[index], ifetch_en_out<=1, stay IDLE. Latency 1 cycle.
  - ifetch_en_in=1 and miss: mem_pc_out<={pc[31:2],2'b00}, mem_en_out<=1, latch index/tag, go MISS.
- MISS:
  - mem_en_out held 1; ifetch_en_in ignored (fetch unit has one outstanding request).
  - mem_en_in=1: data[index]<=mem_inst_in, tag[index]<=latched tag, valid[index]<=1, ifetch_inst_out<=mem_inst_in, ifetch_en_out<=1, mem_en_out<=0, go IDLE.
  - Miss latency = memory latency + 1 cycle.
- flush_in=1 (any state, priority over all other events in that cycle):
  - mem_en_out<=0, ifetch_en_out<=0, go IDLE.
  - No fill even if mem_en_in is coincident.
  - Valid bits and arrays are kept.
  - A request coincident with flush is dropped.
- After IDLE returns, a new request may arrive in the very next cycle.
- Overwrite on conflicting index is unconditional (direct-mapped replacement).

Optional Feature:
- ICACHE_STATS_EN defined:
  - Adds outputs stat_hit_out[31:0] and stat_miss_out[31:0].
  - Counters increment on each accepted IDLE request (hit or miss) and wrap at 2^32.
  - Cleared only by rst_in; flush does not clear them; frozen while rdy_in=0.
  - An aborted miss still counts as a miss.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Cold miss: reset, request pc=0x0000_0100 → mem_en_out=1 with mem_pc_out=0x100 next cycle. Hold until mem_en_in with 0x0010_0093 → ifetch_en_out pulse next cycle, inst=0x0010_0093, mem_en_out=0.
- Hit: repeat pc=0x100 → ifetch_en_out exactly 1 cycle later, inst=0x0010_0093, mem_en_out stays 0 throughout.
- Conflict: pc=0x500 (same index 0x40, different tag, INDEX_WIDTH=8) → miss, fill 0xDEAD_BEEF. Then pc=0x100 → miss again.
- Flush mid-miss: miss on pc=0x200, flush_in=1 two cycles later, then mem_en_in → no ifetch_en_out, no fill. Next request pc=0x200 misses.
- Flush coincident with mem_en_in → flush wins: no output, line not valid. rdy_in=0 for 3 cycles during MISS → mem_en_out/mem_pc_out hold, no pulse.
- Async reset asserted mid-MISS without clock edge → outputs 0 immediately; previously filled pc=0x100 misses afterwards. With ICACHE_STATS_EN, 1 miss + 2 hits gives stat_hit_out=2, stat_miss_out=1.

Source files
------------

// File: rtl/icache_ctrl.sv
// Direct-mapped, one-word-per-line instruction cache in front of the memory controller IF port.
// Define ICACHE_STATS_EN to add hit/miss counters (stat_hit_out / stat_miss_out).
module icache_ctrl #(
  parameter int INDEX_WIDTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        ifetch_en_in,
  input  logic [31:0] ifetch_pc_in,
  output logic        ifetch_en_out,
  output logic [31:0] ifetch_inst_out,
  output logic        mem_en_out,
  output logic [31:0] mem_pc_out,
  input  logic        mem_en_in,
  input  logic [31:0] mem_inst_in,
  input  logic        flush_in
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] stat_hit_out,
  output logic [31:0] stat_miss_out
`endif
);

  localparam int TAG_WIDTH = 32 - 2 - INDEX_WIDTH;
  localparam int LINES     = 1 << INDEX_WIDTH;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MISS = 1'b1;

  logic [31:0]            r_data  [0:LINES-1];
  logic [TAG_WIDTH-1:0]   r_tag   [0:LINES-1];
  logic [LINES-1:0]       r_valid;
  logic [0:0]             r_state;
  logic [INDEX_WIDTH-1:0] r_miss_index;
  logic [TAG_WIDTH-1:0]   r_miss_tag;

  logic [INDEX_WIDTH-1:0] w_index;
  logic [TAG_WIDTH-1:0]   w_tag;
  logic [1:0]             w_unused_pc_bits;
  logic                   w_accept;
  logic                   w_hit;
  logic                   w_miss;
  logic                   w_fill;

  assign w_index          = ifetch_pc_in[INDEX_WIDTH+1:2];
  assign w_tag            = ifetch_pc_in[31:INDEX_WIDTH+2];
  assign w_unused_pc_bits = ifetch_pc_in[1:0];

  // A flush in the same cycle drops both a new request and a returning fill.
  assign w_accept = rdy_in && !flush_in && (r_state == S_IDLE) && ifetch_en_in;
  assign w_hit    = w_accept && r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_miss   = w_accept && !w_hit;
  assign w_fill   = rdy_in && !flush_in && (r_state == S_MISS) && mem_en_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state         <= S_IDLE;
      r_valid         <= '0;
      r_miss_index    <= '0;
      r_miss_tag      <= '0;
      ifetch_en_out   <= 1'b0;
      ifetch_inst_out <= 32'd0;
      mem_en_out      <= 1'b0;
      mem_pc_out      <= 32'd0;
    end else begin
      ifetch_en_out <= 1'b0;
      if (rdy_in) begin
        if (flush_in) begin
          mem_en_out <= 1'b0;
          r_state    <= S_IDLE;
        end else if (w_hit) begin
          ifetch_inst_out <= r_data[w_index];
          ifetch_en_out   <= 1'b1;
        end else if (w_miss) begin
          mem_pc_out   <= {ifetch_pc_in[31:2], 2'b00};
          mem_en_out   <= 1'b1;
          r_miss_index <= w_index;
          r_miss_tag   <= w_tag;
          r_state      <= S_MISS;
        end else if (w_fill) begin
          r_valid[r_miss_index] <= 1'b1;
          ifetch_inst_out       <= mem_inst_in;
          ifetch_en_out         <= 1'b1;
          mem_en_out            <= 1'b0;
          r_state               <= S_IDLE;
        end
      end
    end
  end

  // Storage arrays carry no reset so they map onto RAM; validity lives in r_valid.
  always_ff @(posedge clk_in) begin
    if (w_fill) begin
      r_data[r_miss_index] <= mem_inst_in;
      r_tag[r_miss_index]  <= r_miss_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      stat_hit_out  <= 32'd0;
      stat_miss_out <= 32'd0;
    end else begin
      if (w_hit)  stat_hit_out  <= stat_hit_out + 32'd1;
      if (w_miss) stat_miss_out <= stat_miss_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Scoreboard bench for icache_ctrl: expected fetch words are queued when stimulus is driven.
module tb_icache_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        ifetch_en_in = 1'b0;
  logic [31:0] ifetch_pc_in = 32'd0;
  logic        ifetch_en_out;
  logic [31:0] ifetch_inst_out;
  logic        mem_en_out;
  logic [31:0] mem_pc_out;
  logic        mem_en_in = 1'b0;
  logic [31:0] mem_inst_in = 32'd0;
  logic        flush_in = 1'b0;
`ifdef ICACHE_STATS_EN
  logic [31:0] stat_hit_out;
  logic [31:0] stat_miss_out;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  icache_ctrl dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .ifetch_en_in    (ifetch_en_in),
    .ifetch_pc_in    (ifetch_pc_in),
    .ifetch_en_out   (ifetch_en_out),
    .ifetch_inst_out (ifetch_inst_out),
    .mem_en_out      (mem_en_out),
    .mem_pc_out      (mem_pc_out),
    .mem_en_in       (mem_en_in),
    .mem_inst_in     (mem_inst_in),
    .flush_in        (flush_in)
`ifdef ICACHE_STATS_EN
    ,
    .stat_hit_out    (stat_hit_out),
    .stat_miss_out   (stat_miss_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Every output pulse must match the oldest queued expectation.
  always @(negedge clk_in) begin
    if (ifetch_en_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        $display("fetch: inst=%h expected=%h", ifetch_inst_out, e);
        check("inst", ifetch_inst_out, e);
      end
    end
  end

  task automatic do_req(input logic [31:0] pc);
    @(negedge clk_in);
    ifetch_en_in = 1'b1;
    ifetch_pc_in = pc;
    @(negedge clk_in);
    ifetch_en_in = 1'b0;
  endtask

  task automatic fetch_hit(input logic [31:0] pc, input logic [31:0] data);
    exp_q.push_back(data);
    do_req(pc);
    check("hit_pulse", {31'd0, ifetch_en_out}, 32'd1);
    check("hit_no_mem", {31'd0, mem_en_out}, 32'd0);
  endtask

  task automatic complete_fill(input logic [31:0] data);
    exp_q.push_back(data);
    mem_en_in   = 1'b1;
    mem_inst_in = data;
    @(negedge clk_in);
    mem_en_in = 1'b0;
    check("fill_pulse", {31'd0, ifetch_en_out}, 32'd1);
    check("fill_mem_drop", {31'd0, mem_en_out}, 32'd0);
  endtask

  task automatic start_miss(input logic [31:0] pc);
    do_req(pc);
    check("miss_mem_en", {31'd0, mem_en_out}, 32'd1);
    check("miss_mem_pc", mem_pc_out, {pc[31:2], 2'b00});
    check("miss_no_pulse", {31'd0, ifetch_en_out}, 32'd0);
  endtask

  task automatic fetch_miss(input logic [31:0] pc, input logic [31:0] data, input int lat);
    start_miss(pc);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk_in);
      check("miss_hold", {31'd0, mem_en_out}, 32'd1);
    end
    complete_fill(data);
  endtask

  initial begin
    repeat (3) @(negedge clk_in);
    check("rst_ifetch_en", {31'd0, ifetch_en_out}, 32'd0);
    check("rst_inst", ifetch_inst_out, 32'd0);
    check("rst_mem_en", {31'd0, mem_en_out}, 32'd0);
    check("rst_mem_pc", mem_pc_out, 32'd0);
    rst_in = 1'b0;

    // Cold miss, hit, then conflicting index evicts and re-misses
    fetch_miss(32'h0000_0100, 32'h0010_0093, 2);
    fetch_hit(32'h0000_0100, 32'h0010_0093);
    fetch_miss(32'h0000_0500, 32'hDEAD_BEEF, 1);
    fetch_miss(32'h0000_0100, 32'h0010_0093, 0);
    fetch_hit(32'h0000_0100, 32'h0010_0093);

    // Flush two cycles into a miss; late memory word must not fill
    start_miss(32'h0000_0200);
    @(negedge clk_in);
    flush_in = 1'b1;
    @(negedge clk_in);
    flush_in = 1'b0;
    check("flush_mem_en", {31'd0, mem_en_out}, 32'd0);
    mem_en_in = 1'b1;
    mem_inst_in = 32'h1111_1111;
    @(negedge clk_in);
    mem_en_in = 1'b0;
    check("flush_no_pulse", {31'd0, ifetch_en_out}, 32'd0);
    fetch_miss(32'h0000_0200, 32'h2222_2222, 1);
    fetch_hit(32'h0000_0203, 32'h2222_2222);

    // Flush coincident with the memory response
    start_miss(32'h0000_0300);
    mem_en_in = 1'b1;
    mem_inst_in = 32'h3333_3333;
    flush_in = 1'b1;
    @(negedge clk_in);
    mem_en_in = 1'b0;
    flush_in = 1'b0;
    check("coflush_no_pulse", {31'd0, ifetch_en_out}, 32'd0);
    check("coflush_mem_en", {31'd0, mem_en_out}, 32'd0);
    fetch_miss(32'h0000_0300, 32'h4444_4444, 0);

    // Freeze during MISS; a memory pulse while frozen is ignored
    start_miss(32'h0000_0400);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_en_in = (i == 1);
      mem_inst_in = 32'h5555_5555;
      @(negedge clk_in);
      check("frz_mem_en", {31'd0, mem_en_out}, 32'd1);
      check("frz_mem_pc", mem_pc_out, 32'h0000_0400);
      check("frz_no_pulse", {31'd0, ifetch_en_out}, 32'd0);
    end
    mem_en_in = 1'b0;
    rdy_in = 1'b1;
    @(negedge clk_in);
    check("unfrz_mem_en", {31'd0, mem_en_out}, 32'd1);
    complete_fill(32'h6666_6666);
    fetch_hit(32'h0000_0400, 32'h6666_6666);

    // Async reset mid-miss, observed before any clock edge
    start_miss(32'h0000_0600);
    #2 rst_in = 1'b1;
    #1;
    check("arst_mem_en", {31'd0, mem_en_out}, 32'd0);
    check("arst_mem_pc", mem_pc_out, 32'd0);
    check("arst_inst", ifetch_inst_out, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    fetch_miss(32'h0000_0100, 32'h0010_0093, 1);
    fetch_hit(32'h0000_0100, 32'h0010_0093);
    fetch_hit(32'h0000_0100, 32'h0010_0093);
`ifdef ICACHE_STATS_EN
    check("stat_hit", stat_hit_out, 32'd2);
    check("stat_miss", stat_miss_out, 32'd1);
`endif

    repeat (2) @(negedge clk_in);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
